// File: rtl/msg_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : msg_rx_pkg                                                      |
// | Purpose  : Shared constants for the MsgRouter receive-path header demux:   |
// |            header byte offsets, error codes and FSM state encoding.        |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package msg_rx_pkg;

  // Little-endian header layout: each 16-bit field is low byte first.
  localparam int HEADER_BYTES = 8;
  localparam int SYNC_LO      = 0;
  localparam int SYNC_HI      = 1;
  localparam int LEN_LO       = 2;
  localparam int LEN_HI       = 3;
  localparam int ID_LO        = 4;
  localparam int ID_HI        = 5;
  localparam int SEQ_LO       = 6;
  localparam int SEQ_HI       = 7;

  // ErrorCode values reported with MessageError.
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    ST_HUNT1   = 3'd0,
    ST_HUNT2   = 3'd1,
    ST_HEADER  = 3'd2,
    ST_CHECK   = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/msg_timeout_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : msg_timeout_timer                                               |
// | Purpose  : Inter-byte idle counter. Expired flags the cycle in which the   |
// |            count would reach TIMEOUT_CYCLES-1, so the owner can abort      |
// |            exactly TIMEOUT_CYCLES clocks after the last accepted byte.     |
// | Ports    : Clock   - system clock                                          |
// |            ClearN  - synchronous active-low reset                          |
// |            Restart - clear the count (accepted byte or idle hunting)       |
// |            Enable  - count this cycle                                      |
// |            Expired - timeout reached this cycle                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module msg_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 17
) (
  input  logic Clock,
  input  logic ClearN,
  input  logic Restart,
  input  logic Enable,
  output logic Expired
);

  // Count is 0 in the cycle after a restart, so the value seen in the cycle
  // that is k clocks after the restart is k-1. Flagging one below the limit
  // lets the owner's state register land in its error state on cycle +N.
  localparam logic [TO_W-1:0] C_LIMIT = TO_W'(TIMEOUT_CYCLES - 2);

  logic [TO_W-1:0] r_count;

  always_ff @(posedge Clock) begin
    if (!ClearN) begin
      r_count <= '0;
    end else if (Restart) begin
      r_count <= '0;
    end else if (Enable) begin
      r_count <= r_count + TO_W'(1);
    end
  end

  assign Expired = Enable && (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/msg_header_demux_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : msg_header_demux_p                                              |
// | Purpose  : Hunts for the sync word in the received byte stream, captures  |
// |            the 8-byte little-endian header, validates its length, writes   |
// |            payload bytes to data RAM and reports completion or errors.     |
// | Ports    : Clock, ClearN (sync active-low reset)                           |
// |            MessageByte/MessageByteReady - byte stream in                   |
// |            SyncWord/ByteCount/MessageID/SequenceNumber - header fields     |
// |            MessageComplete/MessageError/ErrorCode - status to controller   |
// |            DataByte/DataAddr/WriteDataByte - payload RAM write port        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module msg_header_demux_p
  import msg_rx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD      = 16'h1234,
  parameter int unsigned MAX_MSG_BYTES  = 1024,
  parameter int unsigned DATA_ADDR_W    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 17
) (
  input  logic                   Clock,
  input  logic                   ClearN,
  input  logic [7:0]             MessageByte,
  input  logic                   MessageByteReady,
  output logic [15:0]            SyncWord,
  output logic [15:0]            ByteCount,
  output logic [15:0]            MessageID,
  output logic [15:0]            SequenceNumber,
  output logic                   MessageComplete,
  output logic                   MessageError,
  output logic [1:0]             ErrorCode,
  output logic [7:0]             DataByte,
  output logic [DATA_ADDR_W-1:0] DataAddr,
  output logic                   WriteDataByte
);

  state_t                 r_state;
  state_t                 w_next;
  logic [7:0]             r_hdr [HEADER_BYTES];
  logic [15:0]            r_count;
  logic [7:0]             r_data;
  logic [DATA_ADDR_W-1:0] r_addr;
  logic                   r_write;
  logic                   r_complete;
  logic [1:0]             r_err_code;

  logic [15:0]            w_byte_count;
  logic [15:0]            w_count_inc;
  logic                   w_len_bad;
  logic                   w_len_hdr_only;
  logic [DATA_ADDR_W-1:0] w_pay_addr;
  logic                   w_expired;
  logic                   w_timer_restart;
  logic                   w_timer_enable;

  logic                   w_hdr_we;
  logic [2:0]             w_hdr_idx;
  logic                   w_cnt_we;
  logic [15:0]            w_cnt_val;
  logic                   w_pay_we;
  logic                   w_addr_clr;
  logic                   w_err_we;
  logic [1:0]             w_err_val;
  logic                   w_complete;

  assign w_byte_count   = {r_hdr[LEN_HI], r_hdr[LEN_LO]};
  assign w_count_inc    = r_count + 16'd1;
  assign w_len_bad      = (w_byte_count < 16'(HEADER_BYTES)) ||
                          ({16'd0, w_byte_count} > MAX_MSG_BYTES);
  assign w_len_hdr_only = (w_byte_count == 16'(HEADER_BYTES));
  // The length check bounds the count, so this truncation never wraps.
  assign w_pay_addr     = DATA_ADDR_W'(r_count - 16'(HEADER_BYTES));

  assign w_timer_restart = MessageByteReady || (r_state == ST_HUNT1);
  assign w_timer_enable  = (r_state == ST_HUNT2) || (r_state == ST_HEADER) ||
                           (r_state == ST_PAYLOAD);

  msg_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timer (
    .Clock   (Clock),
    .ClearN  (ClearN),
    .Restart (w_timer_restart),
    .Enable  (w_timer_enable),
    .Expired (w_expired)
  );

  always_ff @(posedge Clock) begin
    if (!ClearN) begin
      r_state <= ST_HUNT1;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_hdr_we   = 1'b0;
    w_hdr_idx  = 3'(SYNC_LO);
    w_cnt_we   = 1'b0;
    w_cnt_val  = w_count_inc;
    w_pay_we   = 1'b0;
    w_addr_clr = 1'b0;
    w_err_we   = 1'b0;
    w_err_val  = ERR_LEN;
    w_complete = 1'b0;

    unique case (r_state)
      ST_HUNT1: begin
        if (MessageByteReady && (MessageByte == SYNC_WORD[7:0])) begin
          w_hdr_we = 1'b1;
          w_next   = ST_HUNT2;
        end
      end

      ST_HUNT2: begin
        if (MessageByteReady) begin
          if (MessageByte == SYNC_WORD[15:8]) begin
            w_hdr_we  = 1'b1;
            w_hdr_idx = 3'(SYNC_HI);
            w_cnt_we  = 1'b1;
            w_cnt_val = 16'(LEN_LO);
            w_next    = ST_HEADER;
          end else if (MessageByte == SYNC_WORD[7:0]) begin
            // Repeated low sync byte: treat it as a fresh start of sync.
            w_hdr_we = 1'b1;
          end else begin
            w_next = ST_HUNT1;
          end
        end else if (w_expired) begin
          w_err_we  = 1'b1;
          w_err_val = ERR_TIMEOUT;
          w_next    = ST_ERR;
        end
      end

      ST_HEADER: begin
        if (MessageByteReady) begin
          w_hdr_we  = 1'b1;
          w_hdr_idx = r_count[2:0];
          w_cnt_we  = 1'b1;
          if (r_count[2:0] == 3'(SEQ_HI)) begin
            w_next = ST_CHECK;
          end
        end else if (w_expired) begin
          w_err_we  = 1'b1;
          w_err_val = ERR_TIMEOUT;
          w_next    = ST_ERR;
        end
      end

      ST_CHECK: begin
        if (MessageByteReady) begin
          w_err_we  = 1'b1;
          w_err_val = ERR_OVERRUN;
          w_next    = ST_ERR;
        end else if (w_len_bad) begin
          w_err_we  = 1'b1;
          w_err_val = ERR_LEN;
          w_next    = ST_ERR;
        end else if (w_len_hdr_only) begin
          // Header-only: pulse straight from the check so completion lands
          // two clocks after the last header byte, like the payload path.
          w_complete = 1'b1;
          w_next     = ST_DONE;
        end else begin
          w_addr_clr = 1'b1;
          w_cnt_we   = 1'b1;
          w_cnt_val  = 16'(HEADER_BYTES);
          w_next     = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (MessageByteReady) begin
          w_pay_we = 1'b1;
          w_cnt_we = 1'b1;
          if (w_count_inc == w_byte_count) begin
            w_next = ST_DONE;
          end
        end else if (w_expired) begin
          w_err_we  = 1'b1;
          w_err_val = ERR_TIMEOUT;
          w_next    = ST_ERR;
        end
      end

      ST_DONE: begin
        if (MessageByteReady) begin
          w_err_we  = 1'b1;
          w_err_val = ERR_OVERRUN;
          w_next    = ST_ERR;
        end else begin
          // Already pulsed when arriving from the header-only check.
          w_complete = !r_complete;
          w_next     = ST_HUNT1;
        end
      end

      ST_ERR: begin
        w_next = ST_HUNT1;
      end

      default: begin
        w_next = ST_HUNT1;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ClearN) begin
      for (int i = 0; i < HEADER_BYTES; i++) begin
        r_hdr[i] <= '0;
      end
      r_count    <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_complete <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_write    <= 1'b0;
      r_complete <= w_complete;
      if (w_hdr_we) begin
        r_hdr[w_hdr_idx] <= MessageByte;
      end
      if (w_cnt_we) begin
        r_count <= w_cnt_val;
      end
      if (w_pay_we) begin
        r_write <= 1'b1;
        r_data  <= MessageByte;
        r_addr  <= w_pay_addr;
      end else if (w_addr_clr) begin
        r_addr <= '0;
      end
      if (w_err_we) begin
        r_err_code <= w_err_val;
      end
    end
  end

  assign SyncWord        = {r_hdr[SYNC_HI], r_hdr[SYNC_LO]};
  assign ByteCount       = w_byte_count;
  assign MessageID       = {r_hdr[ID_HI], r_hdr[ID_LO]};
  assign SequenceNumber  = {r_hdr[SEQ_HI], r_hdr[SEQ_LO]};
  assign MessageComplete = r_complete;
  assign MessageError    = (r_state == ST_ERR);
  assign ErrorCode       = r_err_code;
  assign DataByte        = r_data;
  assign DataAddr        = r_addr;
  assign WriteDataByte   = r_write;

endmodule
`default_nettype wire
